// File: rtl/loteria_pkg.sv
// Shared types and segment helpers for the loteria_nd digit-entry lottery checker.
// Contents:
//   state_t   ticket phase: ENTRY (collecting digits), READY (all held), RESULT (scored)
//   prize_t   prize tier as driven on the prize output
//   SEG_*     active-low 7-segment images (bit 6 = g ... bit 0 = a)
//   seg7()    active-low decode of a BCD digit 0..9; other codes show blank
package loteria_pkg;

    typedef enum logic [1:0] {
        ENTRY  = 2'd0,
        READY  = 2'd1,
        RESULT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PRIZE_NONE    = 2'd0,
        PRIZE_FIRST   = 2'd1,
        PRIZE_SECOND  = 2'd2,
        PRIZE_JACKPOT = 2'd3
    } prize_t;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_P     = 7'b0001100;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/loteria_nd_if.sv
// Player/board-side bundle of loteria_nd.
//   num, insert, finish            board switches/keys into the checker
//   ledr, hex_dig, hex_pri         LED and 7-segment images (active-low segments)
//   prize, win, err, timeout       scoring result and 1-cycle event pulses
// Modports: master = board/stimulus side, slave = checker side.
interface loteria_nd_if #(
    parameter int unsigned NDIG = 5
);
    logic [3:0]          num;
    logic                insert;
    logic                finish;
    logic [NDIG:0]       ledr;
    logic [7*NDIG-1:0]   hex_dig;
    logic [6:0]          hex_pri;
    logic [1:0]          prize;
    logic                win;
    logic                err;
    logic                timeout;

    modport master (
        output num, insert, finish,
        input  ledr, hex_dig, hex_pri, prize, win, err, timeout
    );

    modport slave (
        input  num, insert, finish,
        output ledr, hex_dig, hex_pri, prize, win, err, timeout
    );
endinterface

// File: rtl/seg7_decode.sv
// Single 7-segment display driver (active-low).
//   digit  in  4  BCD value to show
//   blank  in  1  all segments off (highest priority)
//   dash   in  1  show centre bar only
//   seg    out 7  active-low segments g..a
module seg7_decode
    import loteria_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);
    always_comb begin
        if (blank) begin
            seg = SEG_BLANK;
        end else if (dash) begin
            seg = SEG_DASH;
        end else begin
            seg = seg7(digit);
        end
    end
endmodule

// File: rtl/loteria_nd.sv
// Digit-entry lottery checker. The player enters NDIG decimal digits (one per rising edge of
// insert), then presses finish; the longest run of consecutive position matches against SECRET
// selects the prize tier.
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high; dominates all inputs
//   bus    loteria_nd_if.slave: num/insert/finish in; ledr, hex_dig, hex_pri, prize, win,
//          err (rejected digit pulse), timeout (inactivity clear pulse) out
// Build option: define LOTERIA_TIMEOUT_EN to clear an idle ticket after TIMEOUT_CYC cycles;
// without it timeout is held at 0 and a ticket waits indefinitely.
module loteria_nd
    import loteria_pkg::*;
#(
    parameter int unsigned       NDIG        = 5,
    parameter logic [4*NDIG-1:0] SECRET      = 20'h50967,
    parameter int unsigned       P1_RUN      = 4,
    parameter int unsigned       P2_RUN      = 2,
    parameter int unsigned       TIMEOUT_CYC = 50_000_000
) (
    input  logic         clk,
    input  logic         reset,
    loteria_nd_if.slave  bus
);
    localparam int unsigned IW = $clog2(NDIG + 1);
    typedef logic [IW-1:0] cnt_t;

    state_t     state_q, state_d;
    cnt_t       idx_q, idx_d;
    cnt_t       run_q, run_d;
    cnt_t       best_q, best_d;
    logic [3:0] dig_q [NDIG];
    logic [3:0] dig_d [NDIG];
    prize_t     prize_q, prize_d;
    logic       win_q, win_d;
    logic       err_q, err_d;
    logic       timeout_q, timeout_d;
    logic       insert_q;

    logic       accept;
    logic [3:0] secret_dig;
    cnt_t       run_new;

    function automatic prize_t score(input cnt_t b);
        if (int'(b) == int'(NDIG))        return PRIZE_JACKPOT;
        else if (int'(b) >= int'(P1_RUN)) return PRIZE_FIRST;
        else if (int'(b) >= int'(P2_RUN)) return PRIZE_SECOND;
        else                              return PRIZE_NONE;
    endfunction

    assign accept = bus.insert & ~insert_q & (state_q == ENTRY);

    // Digit 0 sits in the most significant nibble of SECRET.
    always_comb begin
        secret_dig = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (idx_q == cnt_t'(i)) secret_dig = SECRET[4*(int'(NDIG)-1-i) +: 4];
        end
    end

`ifdef LOTERIA_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] tcnt_q, tcnt_d;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        run_d     = run_q;
        best_d    = best_q;
        dig_d     = dig_q;
        prize_d   = prize_q;
        win_d     = win_q;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        run_new   = '0;

        unique case (state_q)
            ENTRY: begin
                if (accept) begin
                    if (bus.num <= 4'd9) begin
                        for (int i = 0; i < int'(NDIG); i++) begin
                            if (idx_q == cnt_t'(i)) dig_d[i] = bus.num;
                        end
                        run_new = (bus.num == secret_dig) ? run_q + 1'b1 : '0;
                        run_d   = run_new;
                        best_d  = (run_new > best_q) ? run_new : best_q;
                        if (idx_q == cnt_t'(NDIG - 1)) begin
                            state_d = READY;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            READY: begin
                if (bus.finish) begin
                    state_d = RESULT;
                    prize_d = score(best_q);
                    win_d   = (score(best_q) != PRIZE_NONE);
                end
            end
            RESULT: ;
            default: state_d = ENTRY;
        endcase

`ifdef LOTERIA_TIMEOUT_EN
        // Counter idles at 0 until the first digit; an accept on the limit cycle wins, and so
        // does a finish that moves the ticket to RESULT.
        tcnt_d = tcnt_q;
        if (accept || state_q == RESULT || (state_q == ENTRY && idx_q == '0)) begin
            tcnt_d = '0;
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
            tcnt_d = '0;
            if (!(state_q == READY && bus.finish)) begin
                state_d   = ENTRY;
                idx_d     = '0;
                run_d     = '0;
                best_d    = '0;
                timeout_d = 1'b1;
                for (int i = 0; i < int'(NDIG); i++) dig_d[i] = '0;
            end
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ENTRY;
            idx_q     <= '0;
            run_q     <= '0;
            best_q    <= '0;
            prize_q   <= PRIZE_NONE;
            win_q     <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            insert_q  <= 1'b0;
            for (int i = 0; i < int'(NDIG); i++) dig_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            run_q     <= run_d;
            best_q    <= best_d;
            prize_q   <= prize_d;
            win_q     <= win_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            insert_q  <= bus.insert;
            dig_q     <= dig_d;
        end
    end

`ifdef LOTERIA_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) tcnt_q <= '0;
        else       tcnt_q <= tcnt_d;
    end
`endif

    // Every slot counts as entered once the ticket has left ENTRY.
    logic [NDIG:0]     ledr;
    logic [7*NDIG-1:0] hex_dig;
    logic [6:0]        hex_pri;

    always_comb begin
        for (int i = 0; i < int'(NDIG); i++) begin
            ledr[i] = (state_q != ENTRY) || (cnt_t'(i) < idx_q);
        end
        ledr[NDIG] = (state_q == RESULT);
    end

    for (genvar g = 0; g < int'(NDIG); g++) begin : g_dig
        seg7_decode u_seg (
            .digit (dig_q[g]),
            .blank (1'b0),
            .dash  (~ledr[g]),
            .seg   (hex_dig[7*(int'(NDIG)-g)-1 -: 7])
        );
    end

    seg7_decode u_seg_pri (
        .digit ({2'b00, prize_q}),
        .blank (state_q != RESULT),
        .dash  (1'b0),
        .seg   (hex_pri)
    );

    assign bus.ledr    = ledr;
    assign bus.hex_dig = hex_dig;
    assign bus.hex_pri = hex_pri;
    assign bus.prize   = prize_q;
    assign bus.win     = win_q;
    assign bus.err     = err_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_loteria_nd.sv
module tb_loteria_nd;
    localparam int NDIG = 5;
    localparam int TO   = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    loteria_nd_if #(.NDIG(NDIG)) bus ();

    loteria_nd #(
        .NDIG        (NDIG),
        .SECRET      (20'h50967),
        .P1_RUN      (4),
        .P2_RUN      (2),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         secret [NDIG] = '{5, 0, 9, 6, 7};
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int   m_dig [NDIG];
    int   m_cnt, m_phase, m_prize, m_idle;   // phase: 0 entry, 1 ready, 2 result
    logic m_err, m_to, m_insq;
    bit   m_valid = 0;

    function automatic int best_run();
        int b = 0;
        int r = 0;
        for (int i = 0; i < m_cnt; i++) begin
            r = (m_dig[i] == secret[i]) ? r + 1 : 0;
            if (r > b) b = r;
        end
        return b;
    endfunction

    function automatic int prize_of(input int b);
        if (b == NDIG) return 3;
        if (b >= 4)    return 1;
        if (b >= 2)    return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        int  p0, c0;
        bit  acc;
        if (reset) begin
            m_valid = 1; m_cnt = 0; m_phase = 0; m_prize = 0; m_idle = 0;
            m_err = 0; m_to = 0; m_insq = 0;
        end else begin
            p0 = m_phase;
            c0 = m_cnt;
            acc = bus.insert && !m_insq && p0 == 0;
            m_err = 0;
            m_to = 0;
            if (p0 == 1 && bus.finish) begin
                m_phase = 2;
                m_prize = prize_of(best_run());
            end
            if (acc) begin
                if (bus.num <= 9) begin
                    m_dig[m_cnt] = int'(bus.num);
                    m_cnt++;
                    if (m_cnt == NDIG) m_phase = 1;
                end else begin
                    m_err = 1;
                end
            end
`ifdef LOTERIA_TIMEOUT_EN
            if (acc || p0 == 2 || (p0 == 0 && c0 == 0)) m_idle = 0;
            else if (m_idle == TO - 1) begin
                m_idle = 0;
                if (!(p0 == 1 && bus.finish)) begin
                    m_cnt = 0; m_phase = 0; m_to = 1;
                end
            end else m_idle++;
`endif
            m_insq = bus.insert;
        end
    end

    always @(negedge clk) begin
        logic [NDIG:0]     e_ledr;
        logic [7*NDIG-1:0] e_hex;
        if (m_valid) begin
            e_hex = '0;
            for (int i = 0; i < NDIG; i++) begin
                e_ledr[i] = (i < m_cnt);
                e_hex = (e_hex << 7) | ((i < m_cnt) ? seg_tab[m_dig[i]] : 7'h3f);
            end
            e_ledr[NDIG] = (m_phase == 2);
            chk("ledr",    64'(bus.ledr),    64'(e_ledr));
            chk("hex_dig", 64'(bus.hex_dig), 64'(e_hex));
            chk("hex_pri", 64'(bus.hex_pri), 64'((m_phase == 2) ? seg_tab[m_prize] : 7'h7f));
            chk("prize",   64'(bus.prize),   64'((m_phase == 2) ? m_prize : 0));
            chk("win",     64'(bus.win),     64'(m_phase == 2 && m_prize != 0));
            chk("err",     64'(bus.err),     64'(m_err));
            chk("timeout", 64'(bus.timeout), 64'(m_to));
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [3:0] d);
        @(negedge clk); bus.num = d; bus.insert = 1'b1;
        @(negedge clk); bus.insert = 1'b0;
    endtask

    task automatic do_finish();
        @(negedge clk); bus.finish = 1'b1;
        @(negedge clk); bus.finish = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic ticket(input int a, b, c, d, e);
        press(4'(a)); press(4'(b)); press(4'(c)); press(4'(d)); press(4'(e));
    endtask

    localparam logic [34:0] DASHES = {5{7'h3f}};

    initial begin
        bus.num = '0; bus.insert = 1'b0; bus.finish = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ledr",    64'(bus.ledr),    64'(6'b000000));
        chk("rst_hex_dig", 64'(bus.hex_dig), 64'(DASHES));
        chk("rst_hex_pri", 64'(bus.hex_pri), 64'(7'h7f));
        chk("rst_prize",   64'(bus.prize),   64'(0));
        reset = 1'b0;

        // jackpot
        ticket(5, 0, 9, 6, 7);
        chk("t1_ready_ledr", 64'(bus.ledr), 64'(6'b011111));
        do_finish();
        chk("t1_prize",   64'(bus.prize),   64'(3));
        chk("t1_win",     64'(bus.win),     64'(1));
        chk("t1_ledr",    64'(bus.ledr),    64'(6'b111111));
        chk("t1_hex_dig", 64'(bus.hex_dig), 64'({7'h12, 7'h40, 7'h10, 7'h02, 7'h78}));
        chk("t1_hex_pri", 64'(bus.hex_pri), 64'(7'h30));
        press(4'd12);
        chk("t1_result_no_err", 64'(bus.err), 64'(0));

        // first prize; last digit arrives together with finish
        do_reset();
        press(4'd5); press(4'd0); press(4'd9); press(4'd6);
        @(negedge clk); bus.num = 4'd1; bus.insert = 1'b1; bus.finish = 1'b1;
        @(negedge clk); bus.insert = 1'b0; bus.finish = 1'b0;
        chk("t2_finish_ignored", 64'(bus.ledr), 64'(6'b011111));
        press(4'd12);
        chk("t2_ready_no_err", 64'(bus.err), 64'(0));
        do_finish();
        chk("t2_prize", 64'(bus.prize), 64'(1));
        chk("t2_win",   64'(bus.win),   64'(1));

        // second prize, then no prize
        do_reset();
        ticket(1, 0, 9, 2, 2);
        do_finish();
        chk("t3a_prize", 64'(bus.prize), 64'(2));
        do_reset();
        ticket(1, 2, 3, 4, 5);
        do_finish();
        chk("t3b_prize",   64'(bus.prize),   64'(0));
        chk("t3b_win",     64'(bus.win),     64'(0));
        chk("t3b_hex_pri", 64'(bus.hex_pri), 64'(7'h40));

        // rejected digit and held insert
        do_reset();
        press(4'd12);
        chk("t4_err_pulse", 64'(bus.err),  64'(1));
        chk("t4_err_ledr",  64'(bus.ledr), 64'(0));
        @(negedge clk);
        chk("t4_err_gone",  64'(bus.err),  64'(0));
        @(negedge clk); bus.num = 4'd3; bus.insert = 1'b1;
        repeat (10) @(negedge clk);
        bus.insert = 1'b0;
        chk("t4_held_one", 64'(bus.ledr), 64'(6'b000001));

        // finish too early, then reset mid-ticket
        press(4'd0); press(4'd8);
        do_finish();
        chk("t5_early_finish", 64'(bus.ledr), 64'(6'b000111));
        do_reset();
        chk("t5_rst_ledr", 64'(bus.ledr),    64'(0));
        chk("t5_rst_hex",  64'(bus.hex_dig), 64'(DASHES));

`ifdef LOTERIA_TIMEOUT_EN
        begin
            int wait_n = 0;
            bit seen = 0;
            press(4'd5); press(4'd0);
            for (int i = 1; i <= 20 && !seen; i++) begin
                @(negedge clk);
                if (bus.timeout) begin seen = 1; wait_n = i; end
            end
            chk("t6_timeout_seen", 64'(seen),        64'(1));
            chk("t6_timeout_cyc",  64'(wait_n),      64'(16));
            chk("t6_ledr",         64'(bus.ledr),    64'(0));
            chk("t6_hex",          64'(bus.hex_dig), 64'(DASHES));
        end
`else
        press(4'd5); press(4'd0);
        repeat (40) @(negedge clk);
        chk("t6_no_timeout_ledr", 64'(bus.ledr), 64'(6'b000011));
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
